// File: rtl/ex_mdu_pkg.sv
// Shared definitions for the EX-stage multiply/divide unit: op encodings,
// default latencies and the single-cycle arithmetic that fills the shadow result.
package ex_mdu_pkg;

  localparam logic [2:0] MDU_MULT  = 3'd0;
  localparam logic [2:0] MDU_MULTU = 3'd1;
  localparam logic [2:0] MDU_DIV   = 3'd2;
  localparam logic [2:0] MDU_DIVU  = 3'd3;
  localparam logic [2:0] MDU_MTHI  = 3'd4;
  localparam logic [2:0] MDU_MTLO  = 3'd5;

  localparam int MDU_MULT_CYCLES = 5;
  localparam int MDU_DIV_CYCLES  = 10;

  typedef struct packed {
    logic        wr;
    logic [31:0] h;
    logic [31:0] l;
  } md_res_t;

  function automatic md_res_t md_compute(input logic [2:0]  op,
                                         input logic [31:0] a,
                                         input logic [31:0] b);
    md_res_t     res;
    logic        sx;
    logic [63:0] a64;
    logic [63:0] b64;
    logic [63:0] prod;
    logic        neg_a;
    logic        neg_b;
    logic [31:0] ua;
    logic [31:0] ub;
    logic [31:0] q;
    logic [31:0] r;
    res   = '0;
    sx    = (op == MDU_MULT);
    a64   = {{32{sx & a[31]}}, a};
    b64   = {{32{sx & b[31]}}, b};
    prod  = a64 * b64;
    // Signed divide runs on magnitudes so MIN/-1 wraps cleanly instead of overflowing.
    neg_a = (op == MDU_DIV) & a[31];
    neg_b = (op == MDU_DIV) & b[31];
    ua    = neg_a ? (~a + 32'd1) : a;
    ub    = neg_b ? (~b + 32'd1) : b;
    if (ub == 32'd0) ub = 32'd1;
    q     = ua / ub;
    r     = ua % ub;
    if (neg_a ^ neg_b) q = ~q + 32'd1;
    if (neg_a)         r = ~r + 32'd1;
    case (op)
      MDU_MULT, MDU_MULTU: begin
        res.wr = 1'b1;
        res.h  = prod[63:32];
        res.l  = prod[31:0];
      end
      MDU_DIV, MDU_DIVU: begin
        res.wr = (b != 32'd0);
        res.h  = r;
        res.l  = q;
      end
      default: res = '0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/ex_mdu.sv
// Multi-cycle mult/div with HI/LO: result computed at accept into a shadow, committed N cycles later.
// busy stays high for N cycles after a mult/div accept; starts while busy are dropped.
module ex_mdu
  import ex_mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MDU_MULT_CYCLES,
  parameter int DIV_CYCLES  = MDU_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  logic [CNT_W-1:0] cnt;
  md_res_t          shadow;
  md_res_t          res_nxt;
  logic             accept;

  assign busy    = (cnt != '0);
  assign accept  = start & ~busy;
  assign res_nxt = md_compute(op, src_a, src_b);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt    <= '0;
      shadow <= '0;
      hi     <= '0;
      lo     <= '0;
    end else if (accept) begin
      case (op)
        MDU_MULT, MDU_MULTU: begin
          shadow <= res_nxt;
          cnt    <= CNT_W'(MULT_CYCLES);
        end
        MDU_DIV, MDU_DIVU: begin
          shadow <= res_nxt;
          cnt    <= CNT_W'(DIV_CYCLES);
        end
        MDU_MTHI: hi <= src_a;
        MDU_MTLO: lo <= src_a;
        default: ;
      endcase
    end else if (busy) begin
      cnt <= cnt - CNT_W'(1);
      // Divide by zero leaves shadow.wr clear, so HI/LO keep their old values.
      if (cnt == CNT_W'(1) && shadow.wr) begin
        hi <= shadow.h;
        lo <= shadow.l;
      end
    end
  end

endmodule

// File: tb/tb_ex_mdu.sv
// Self-checking bench for ex_mdu: directed scenarios plus randomized ops against a longint reference model.
module tb_ex_mdu;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;
  localparam int LAT_MULT = 5;
  localparam int LAT_DIV  = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] src_a = 32'd0;
  logic [31:0] src_b = 32'd0;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ex_mdu #(.MULT_CYCLES(LAT_MULT), .DIV_CYCLES(LAT_DIV)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .src_a(src_a), .src_b(src_b), .busy(busy), .hi(hi), .lo(lo)
  );

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Reference: architectural meaning of each op in plain 64-bit arithmetic.
  task automatic model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] ih, input logic [31:0] il,
                       output logic [31:0] oh, output logic [31:0] ol, output int cyc);
    longint      sa, sb, q, r;
    logic [63:0] p;
    oh = ih; ol = il; cyc = 0;
    case (o)
      OP_MULT: begin
        sa = $signed(a); sb = $signed(b); p = 64'(sa * sb);
        oh = p[63:32]; ol = p[31:0]; cyc = LAT_MULT;
      end
      OP_MULTU: begin
        p = {32'd0, a} * {32'd0, b};
        oh = p[63:32]; ol = p[31:0]; cyc = LAT_MULT;
      end
      OP_DIV: begin
        cyc = LAT_DIV;
        if (b != 32'd0) begin
          sa = $signed(a); sb = $signed(b); q = sa / sb; r = sa % sb;
          ol = q[31:0]; oh = r[31:0];
        end
      end
      OP_DIVU: begin
        cyc = LAT_DIV;
        if (b != 32'd0) begin ol = a / b; oh = a % b; end
      end
      OP_MTHI: oh = a;
      OP_MTLO: ol = a;
      default: ;
    endcase
  endtask

  // Drives one accepted start, then scrambles operands while busy; reports busy length and whether HI/LO held.
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       output int cyc, output bit held);
    logic [31:0] oh, ol;
    oh = hi; ol = lo;
    op = o; src_a = a; src_b = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; op = 3'($urandom); src_a = $urandom; src_b = $urandom;
    cyc = 0; held = 1'b1;
    while (busy === 1'b1 && cyc < 100) begin
      if (hi !== oh || lo !== ol) held = 1'b0;
      cyc++;
      @(posedge clk); #1;
      src_a = $urandom; src_b = $urandom;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #12;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (hi !== 32'd0) begin errors++; $display("FAIL reset_hi got %h want 0", hi); end
    checks++; if (lo !== 32'd0) begin errors++; $display("FAIL reset_lo got %h want 0", lo); end
    #1 reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_mult();
    int cyc; bit held;
    issue(OP_MULT, 32'hFFFFFFFE, 32'd3, cyc, held);
    checks++; if (cyc != 5) begin errors++; $display("FAIL mult_lat got %0d want 5", cyc); end
    checks++; if (!held) begin errors++; $display("FAIL mult_hold got changed want held"); end
    checks++; if (hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL mult_hi got %h want ffffffff", hi); end
    checks++; if (lo !== 32'hFFFFFFFA) begin errors++; $display("FAIL mult_lo got %h want fffffffa", lo); end
  endtask

  task automatic test_multu();
    int cyc; bit held;
    issue(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, cyc, held);
    checks++; if (cyc != 5) begin errors++; $display("FAIL multu_lat got %0d want 5", cyc); end
    checks++; if (hi !== 32'hFFFFFFFE) begin errors++; $display("FAIL multu_hi got %h want fffffffe", hi); end
    checks++; if (lo !== 32'h00000001) begin errors++; $display("FAIL multu_lo got %h want 00000001", lo); end
  endtask

  task automatic test_div();
    int cyc; bit held;
    issue(OP_DIV, 32'hFFFFFFF9, 32'd2, cyc, held);
    checks++; if (cyc != 10) begin errors++; $display("FAIL div_lat got %0d want 10", cyc); end
    checks++; if (!held) begin errors++; $display("FAIL div_hold got changed want held"); end
    checks++; if (lo !== 32'hFFFFFFFD) begin errors++; $display("FAIL div_lo got %h want fffffffd", lo); end
    checks++; if (hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL div_hi got %h want ffffffff", hi); end
    issue(OP_DIV, 32'h80000000, 32'hFFFFFFFF, cyc, held);
    checks++; if (lo !== 32'h80000000) begin errors++; $display("FAIL divmin_lo got %h want 80000000", lo); end
    checks++; if (hi !== 32'd0) begin errors++; $display("FAIL divmin_hi got %h want 0", hi); end
  endtask

  task automatic test_div_zero();
    int cyc; bit held;
    issue(OP_MTHI, 32'h11, 32'd0, cyc, held);
    issue(OP_MTLO, 32'h22, 32'd0, cyc, held);
    issue(OP_DIVU, 32'd5, 32'd0, cyc, held);
    checks++; if (cyc != 10) begin errors++; $display("FAIL divz_lat got %0d want 10", cyc); end
    checks++; if (hi !== 32'h11) begin errors++; $display("FAIL divz_hi got %h want 00000011", hi); end
    checks++; if (lo !== 32'h22) begin errors++; $display("FAIL divz_lo got %h want 00000022", lo); end
  endtask

  task automatic test_busy_ignore();
    int cyc; bit held;
    op = OP_MULT; src_a = 32'd7; src_b = 32'hFFFFFFFD; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; cyc = 0;
    while (busy === 1'b1 && cyc < 100) begin
      cyc++;
      if (cyc == 2) begin start = 1'b1; op = OP_DIV; src_a = 32'd100; src_b = 32'd7; end
      else start = 1'b0;
      @(posedge clk); #1;
    end
    start = 1'b0;
    checks++; if (cyc != 5) begin errors++; $display("FAIL ign_lat got %0d want 5", cyc); end
    checks++; if (hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL ign_hi got %h want ffffffff", hi); end
    checks++; if (lo !== 32'hFFFFFFEB) begin errors++; $display("FAIL ign_lo got %h want ffffffeb", lo); end
    issue(OP_MTHI, 32'hABCD, 32'd0, cyc, held);
    checks++; if (cyc != 0) begin errors++; $display("FAIL mthi_busy got %0d want 0", cyc); end
    checks++; if (hi !== 32'hABCD) begin errors++; $display("FAIL mthi_hi got %h want 0000abcd", hi); end
    checks++; if (lo !== 32'hFFFFFFEB) begin errors++; $display("FAIL mthi_lo got %h want ffffffeb", lo); end
  endtask

  task automatic test_reset_mid();
    int cyc; bit held;
    issue(OP_MTHI, 32'h1234, 32'd0, cyc, held);
    issue(OP_MTLO, 32'h5678, 32'd0, cyc, held);
    op = OP_DIV; src_a = 32'd1000; src_b = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rmid_pre_busy got %b want 1", busy); end
    #2 reset = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy got %b want 0", busy); end
    checks++; if (hi !== 32'd0) begin errors++; $display("FAIL rmid_hi got %h want 0", hi); end
    checks++; if (lo !== 32'd0) begin errors++; $display("FAIL rmid_lo got %h want 0", lo); end
    #1 reset = 1'b1;
    repeat (15) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rpost_busy got %b want 0", busy); end
    checks++; if (hi !== 32'd0 || lo !== 32'd0) begin
      errors++; $display("FAIL rpost_hilo got %h_%h want 0_0", hi, lo);
    end
  endtask

  // Each op issues the cycle busy drops, so this also covers back-to-back accepts.
  task automatic test_random_back_to_back();
    logic [31:0] mh, ml, eh, el, a, b;
    logic [2:0]  o;
    int          ecyc, cyc;
    bit          held;
    mh = 32'd0; ml = 32'd0;
    for (int i = 0; i < 60; i++) begin
      o = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 5))
        0: a = 32'h80000000;
        1: a = 32'($urandom_range(0, 20));
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: b = 32'hFFFFFFFF;
        default: b = $urandom;
      endcase
      model(o, a, b, mh, ml, eh, el, ecyc);
      issue(o, a, b, cyc, held);
      checks++; if (cyc != ecyc) begin errors++; $display("FAIL rnd%0d_lat op %0d got %0d want %0d", i, o, cyc, ecyc); end
      checks++; if (!held) begin errors++; $display("FAIL rnd%0d_hold op %0d got changed want held", i, o); end
      checks++; if (hi !== eh) begin errors++; $display("FAIL rnd%0d_hi op %0d a %h b %h got %h want %h", i, o, a, b, hi, eh); end
      checks++; if (lo !== el) begin errors++; $display("FAIL rnd%0d_lo op %0d a %h b %h got %h want %h", i, o, a, b, lo, el); end
      mh = eh; ml = el;
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_multu();
    test_div();
    test_div_zero();
    test_busy_ignore();
    test_reset_mid();
    test_random_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
